// File: rtl/exe_stage_unit.sv
// Execute stage: operand-2 generation, ALU, NZCV status register, branch target, EX/MEM register.
// Latency: ALU/branch outputs combinational; EX/MEM register and status_reg update 1 cycle later.
// Backpressure: freeze holds the EX/MEM register and blocks the status update until it drops.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   freeze                memory-wait stall for the EX/MEM register and status_reg
//   exe_cmd, s_in, b_in   ALU op, status-update enable, branch flag from ID/EX
//   mem_r_en_in, mem_w_en_in, wb_en_in   control carried into EX/MEM
//   imm_in, shifter_operand              operand-2 selection and encoding
//   signed_imm_24, pc_in                 branch offset (words) and PC+4
//   val_rn, val_rm, dest_in              operands and destination index
//   status_reg                           registered {N,Z,C,V}, fed back to ID
//   branch_taken, branch_address         combinational branch outputs
//   alu_res, st_val, dest_out, wb_en_out, mem_r_en_out, mem_w_en_out   EX/MEM register

module exe_stage_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        freeze,
  input  logic [3:0]  exe_cmd,
  input  logic        s_in,
  input  logic        b_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        wb_en_in,
  input  logic        imm_in,
  input  logic [11:0] shifter_operand,
  input  logic [23:0] signed_imm_24,
  input  logic [31:0] pc_in,
  input  logic [31:0] val_rn,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest_in,
  output logic [3:0]  status_reg,
  output logic        branch_taken,
  output logic [31:0] branch_address,
  output logic [31:0] alu_res,
  output logic [31:0] st_val,
  output logic [3:0]  dest_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out
);

  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // EX/MEM pipeline register contents
  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
  } ex_mem_t;

  ex_mem_t ex_mem_q;
  ex_mem_t ex_mem_d;

  // ---------------------------------------------------------------------------
  // Operand 2
  // ---------------------------------------------------------------------------
  logic [4:0]  rot_amt;
  logic [31:0] imm_word;
  logic [63:0] imm_dbl;
  logic [31:0] imm_rot;
  logic [4:0]  shift_imm;
  logic [1:0]  shift_type;
  logic [63:0] rm_dbl;
  logic [31:0] rm_shifted;
  logic [31:0] val2;

  assign rot_amt  = {shifter_operand[11:8], 1'b0};
  assign imm_word = {24'b0, shifter_operand[7:0]};
  // Rotate right implemented as a right shift of the doubled word; low half is the result.
  assign imm_dbl  = {imm_word, imm_word} >> rot_amt;
  assign imm_rot  = imm_dbl[31:0];

  assign shift_imm  = shifter_operand[11:7];
  assign shift_type = shifter_operand[6:5];
  assign rm_dbl     = {val_rm, val_rm} >> shift_imm;

  // A zero shift amount leaves val_rm untouched for every shift type (no RRX / #32 forms).
  always_comb begin
    rm_shifted = val_rm;
    case (shift_type)
      2'b00:   rm_shifted = val_rm << shift_imm;
      2'b01:   rm_shifted = val_rm >> shift_imm;
      2'b10:   rm_shifted = $signed(val_rm) >>> shift_imm;
      default: rm_shifted = rm_dbl[31:0];
    endcase
  end

  // Memory ops take the raw 12-bit offset regardless of the I bit.
  always_comb begin
    if (mem_r_en_in || mem_w_en_in) begin
      val2 = {20'b0, shifter_operand};
    end else if (imm_in) begin
      val2 = imm_rot;
    end else begin
      val2 = rm_shifted;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------------
  logic        c_prev;
  logic        v_prev;
  logic [32:0] alu_sum;
  logic [31:0] alu_out;
  logic [31:0] op_b;
  logic        is_arith;
  logic        carry_out;
  logic        overflow;
  logic [3:0]  flags_next;

  assign c_prev = status_reg[1];
  assign v_prev = status_reg[0];

  // Subtraction is done as Rn + ~Val2 + 1 (or + C for SBC), so the carry-out is
  // directly the NOT-borrow flag and overflow uses the same rule as addition.
  always_comb begin
    alu_sum  = 33'd0;
    op_b     = val2;
    is_arith = 1'b0;
    case (exe_cmd)
      CMD_MOV: alu_sum = {1'b0, val2};
      CMD_MVN: alu_sum = {1'b0, ~val2};
      CMD_ADD: begin
        is_arith = 1'b1;
        alu_sum  = {1'b0, val_rn} + {1'b0, val2};
      end
      CMD_ADC: begin
        is_arith = 1'b1;
        alu_sum  = {1'b0, val_rn} + {1'b0, val2} + {32'b0, c_prev};
      end
      CMD_SUB: begin
        is_arith = 1'b1;
        op_b     = ~val2;
        alu_sum  = {1'b0, val_rn} + {1'b0, ~val2} + 33'd1;
      end
      CMD_SBC: begin
        is_arith = 1'b1;
        op_b     = ~val2;
        alu_sum  = {1'b0, val_rn} + {1'b0, ~val2} + {32'b0, c_prev};
      end
      CMD_AND: alu_sum = {1'b0, val_rn & val2};
      CMD_ORR: alu_sum = {1'b0, val_rn | val2};
      CMD_EOR: alu_sum = {1'b0, val_rn ^ val2};
      default: alu_sum = 33'd0;
    endcase
  end

  assign alu_out   = alu_sum[31:0];
  assign carry_out = alu_sum[32];
  assign overflow  = (val_rn[31] == op_b[31]) && (alu_out[31] != val_rn[31]);

  // Logic and move ops preserve C and V.
  assign flags_next = {alu_out[31],
                       (alu_out == 32'd0),
                       is_arith ? carry_out : c_prev,
                       is_arith ? overflow  : v_prev};

  // ---------------------------------------------------------------------------
  // Branch target
  // ---------------------------------------------------------------------------
  assign branch_taken   = b_in;
  assign branch_address = pc_in + {{6{signed_imm_24[23]}}, signed_imm_24, 2'b00};

  // ---------------------------------------------------------------------------
  // Status register and EX/MEM register
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_mem_d          = '0;
    ex_mem_d.alu_res  = alu_out;
    ex_mem_d.st_val   = val_rm;
    ex_mem_d.dest     = dest_in;
    ex_mem_d.wb_en    = wb_en_in;
    ex_mem_d.mem_r_en = mem_r_en_in;
    ex_mem_d.mem_w_en = mem_w_en_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_mem_q <= '0;
    end else if (!freeze) begin
      ex_mem_q <= ex_mem_d;
    end
  end

  // A frozen instruction is re-presented each cycle; flags commit only on the
  // unfrozen edge, so the update happens exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_reg <= 4'b0000;
    end else if (s_in && !freeze && (exe_cmd != CMD_NOP)) begin
      status_reg <= flags_next;
    end
  end

  assign alu_res      = ex_mem_q.alu_res;
  assign st_val       = ex_mem_q.st_val;
  assign dest_out     = ex_mem_q.dest;
  assign wb_en_out    = ex_mem_q.wb_en;
  assign mem_r_en_out = ex_mem_q.mem_r_en;
  assign mem_w_en_out = ex_mem_q.mem_w_en;

endmodule

// File: tb/tb_exe_stage_unit.sv
module tb_exe_stage_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic [3:0]  exe_cmd;
  logic        s_in, b_in, mem_r_en_in, mem_w_en_in, wb_en_in, imm_in;
  logic [11:0] shifter_operand;
  logic [23:0] signed_imm_24;
  logic [31:0] pc_in, val_rn, val_rm;
  logic [3:0]  dest_in;
  logic [3:0]  status_reg;
  logic        branch_taken;
  logic [31:0] branch_address, alu_res, st_val;
  logic [3:0]  dest_out;
  logic        wb_en_out, mem_r_en_out, mem_w_en_out;

  always #5 clk = ~clk;

  exe_stage_unit dut (
    .clk(clk), .reset(reset), .freeze(freeze), .exe_cmd(exe_cmd), .s_in(s_in), .b_in(b_in),
    .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .wb_en_in(wb_en_in), .imm_in(imm_in),
    .shifter_operand(shifter_operand), .signed_imm_24(signed_imm_24), .pc_in(pc_in),
    .val_rn(val_rn), .val_rm(val_rm), .dest_in(dest_in), .status_reg(status_reg),
    .branch_taken(branch_taken), .branch_address(branch_address), .alu_res(alu_res),
    .st_val(st_val), .dest_out(dest_out), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .mem_w_en_out(mem_w_en_out)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] st;
    logic [3:0]  dest;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  nzcv;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_exp;
  logic [3:0] m_nzcv;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference operand-2: bit-at-a-time rotates and shifts.
  function automatic logic [31:0] model_val2(input logic mr, input logic mw, input logic imm,
                                              input logic [11:0] shop, input logic [31:0] rm);
    logic [31:0] r;
    int n;
    if (mr || mw) return {20'b0, shop};
    if (imm) begin
      r = {24'b0, shop[7:0]};
      n = 2 * int'(shop[11:8]);
      for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
      return r;
    end
    r = rm;
    n = int'(shop[11:7]);
    for (int i = 0; i < n; i++) begin
      case (shop[6:5])
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[31], r[31:1]};
        default: r = {r[0], r[31:1]};
      endcase
    end
    return r;
  endfunction

  // Reference ALU using 64-bit integer arithmetic for carry and overflow.
  task automatic model_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                           input logic [3:0] nz_in, output logic [31:0] res, output logic [3:0] nz_out);
    longint ua, ub, sa, sb, sv, ci, lim;
    logic c, v;
    ua  = longint'({32'b0, rn});
    ub  = longint'({32'b0, v2});
    sa  = longint'($signed(rn));
    sb  = longint'($signed(v2));
    ci  = nz_in[1] ? 64'sd1 : 64'sd0;
    lim = 64'sd4294967296;
    c   = nz_in[1];
    v   = nz_in[0];
    sv  = 0;
    res = 32'd0;
    case (cmd)
      4'b0001: res = v2;
      4'b1001: res = ~v2;
      4'b0010: begin res = 32'(ua + ub); c = (ua + ub) >= lim; sv = sa + sb; end
      4'b0011: begin res = 32'(ua + ub + ci); c = (ua + ub + ci) >= lim; sv = sa + sb + ci; end
      4'b0100: begin res = 32'(ua - ub); c = ua >= ub; sv = sa - sb; end
      4'b0101: begin res = 32'(ua - ub - (1 - ci)); c = ua >= ub + (1 - ci); sv = sa - sb - (1 - ci); end
      4'b0110: res = rn & v2;
      4'b0111: res = rn | v2;
      4'b1000: res = rn ^ v2;
      default: res = 32'd0;
    endcase
    if (cmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101})
      v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
    nz_out = {res[31], (res == 32'd0), c, v};
  endtask

  task automatic drive(input logic [3:0] cmd, input logic s, input logic b, input logic mr,
                       input logic mw, input logic wb, input logic imm, input logic [11:0] shop,
                       input logic [23:0] simm, input logic [31:0] pc, input logic [31:0] rn,
                       input logic [31:0] rm, input logic [3:0] dst, input logic frz);
    logic [31:0] v2, res;
    logic [3:0]  nz;
    exp_t e;
    exe_cmd = cmd; s_in = s; b_in = b; mem_r_en_in = mr; mem_w_en_in = mw; wb_en_in = wb;
    imm_in = imm; shifter_operand = shop; signed_imm_24 = simm; pc_in = pc;
    val_rn = rn; val_rm = rm; dest_in = dst; freeze = frz;
    if (frz) begin
      sb_q.push_back(last_exp);
    end else begin
      v2 = model_val2(mr, mw, imm, shop, rm);
      model_alu(cmd, rn, v2, m_nzcv, res, nz);
      if (s && cmd != 4'b0000) m_nzcv = nz;
      e = '{alu: res, st: rm, dest: dst, wb: wb, mr: mr, mw: mw, nzcv: m_nzcv};
      last_exp = e;
      sb_q.push_back(e);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("alu_res", alu_res, e.alu);
      check("st_val", st_val, e.st);
      check("dest_out", 32'(dest_out), 32'(e.dest));
      check("ctrl", 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'({e.wb, e.mr, e.mw}));
      check("status", 32'(status_reg), 32'(e.nzcv));
    end
  endtask

  task automatic check_branch();
    longint off;
    #1;
    off = signed_imm_24[23] ? longint'({40'b0, signed_imm_24}) - 64'sd16777216
                            : longint'({40'b0, signed_imm_24});
    check("br_taken", 32'(branch_taken), 32'(b_in));
    check("br_addr", branch_address, 32'(longint'({32'b0, pc_in}) + off * 4));
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_alu"}, alu_res, 32'd0);
    check({tag, "_st"}, st_val, 32'd0);
    check({tag, "_dest"}, 32'(dest_out), 32'd0);
    check({tag, "_ctrl"}, 32'({wb_en_out, mem_r_en_out, mem_w_en_out}), 32'd0);
    check({tag, "_status"}, 32'(status_reg), 32'd0);
  endtask

  initial begin
    reset = 1'b1; freeze = 1'b0; exe_cmd = 4'd0; s_in = 0; b_in = 0; mem_r_en_in = 0;
    mem_w_en_in = 0; wb_en_in = 0; imm_in = 0; shifter_operand = '0; signed_imm_24 = '0;
    pc_in = '0; val_rn = '0; val_rm = '0; dest_in = '0;
    m_nzcv = 4'd0; last_exp = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst_init");
    @(negedge clk);
    reset = 1'b0;

    // ADDS with immediate: signed overflow into bit 31
    drive(4'b0010, 1, 0, 0, 0, 1, 1, 12'h001, 24'd0, 32'd0, 32'h7FFFFFFF, 32'd0, 4'd1, 0);
    tick();
    check("adds_res", alu_res, 32'h80000000);
    check("adds_flags", 32'(status_reg), 32'b1001);

    // MOV rotate-immediate and register shifts
    drive(4'b0001, 0, 0, 0, 0, 1, 1, 12'h2FF, 24'd0, 32'd0, 32'd0, 32'd0, 4'd2, 0);
    tick();
    check("mov_rot", alu_res, 32'hF000000F);
    drive(4'b0001, 0, 0, 0, 0, 1, 0, 12'h220, 24'd0, 32'd0, 32'd0, 32'h80000000, 4'd3, 0);
    tick();
    check("mov_lsr4", alu_res, 32'h08000000);
    drive(4'b0001, 0, 0, 0, 0, 1, 0, 12'h240, 24'd0, 32'd0, 32'd0, 32'h80000000, 4'd3, 0);
    tick();
    check("mov_asr4", alu_res, 32'hF8000000);
    drive(4'b0001, 0, 0, 0, 0, 1, 0, 12'h460, 24'd0, 32'd0, 32'd0, 32'h12345678, 4'd4, 0);
    tick();
    check("mov_ror8", alu_res, 32'h78123456);
    drive(4'b0001, 0, 0, 0, 0, 1, 0, 12'hF80, 24'd0, 32'd0, 32'd0, 32'h00000003, 4'd4, 0);
    tick();
    drive(4'b0001, 0, 0, 0, 0, 1, 0, 12'h040, 24'd0, 32'd0, 32'd0, 32'h80000001, 4'd4, 0);
    tick();
    check("mov_asr0", alu_res, 32'h80000001);

    // SUBS equal operands, then ADC consuming C=1
    drive(4'b0100, 1, 0, 0, 0, 0, 0, 12'h000, 24'd0, 32'd0, 32'd5, 32'd5, 4'd5, 0);
    tick();
    check("subs_res", alu_res, 32'd0);
    check("subs_flags", 32'(status_reg), 32'b0110);
    drive(4'b0011, 1, 0, 0, 0, 1, 0, 12'h000, 24'd0, 32'd0, 32'd1, 32'd1, 4'd6, 0);
    tick();
    check("adc_res", alu_res, 32'd3);
    drive(4'b0101, 1, 0, 0, 0, 1, 0, 12'h000, 24'd0, 32'd0, 32'd10, 32'd3, 4'd6, 0);
    tick();
    drive(4'b0010, 1, 0, 0, 0, 1, 1, 12'h001, 24'd0, 32'd0, 32'hFFFFFFFF, 32'd0, 4'd7, 0);
    tick();

    // ADCS frozen for three cycles, then released
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, 1, 0, 0, 0, 1, 0, 12'h000, 24'd0, 32'd0, 32'h10, 32'h20, 4'd8, 1);
      tick();
      check("frz_status", 32'(status_reg), 32'b0110);
    end
    drive(4'b0011, 1, 0, 0, 0, 1, 0, 12'h000, 24'd0, 32'd0, 32'h10, 32'h20, 4'd8, 0);
    tick();
    check("rel_res", alu_res, 32'h31);
    check("rel_status", 32'(status_reg), 32'b0000);
    drive(4'd0, 0, 0, 0, 0, 0, 0, 12'h000, 24'd0, 32'd0, 32'd0, 32'd0, 4'd0, 0);
    tick();

    // LDR / STR address generation
    drive(4'b0010, 0, 0, 1, 0, 1, 0, 12'hFFF, 24'd0, 32'd0, 32'h1000, 32'd0, 4'd9, 0);
    tick();
    check("ldr_addr", alu_res, 32'h1FFF);
    check("ldr_ren", 32'(mem_r_en_out), 32'd1);
    drive(4'b0010, 0, 0, 0, 1, 0, 1, 12'h004, 24'd0, 32'd0, 32'h2000, 32'hDEADBEEF, 4'd0, 0);
    tick();

    // Branch target, including wrap
    drive(4'd0, 0, 1, 0, 0, 0, 0, 12'h000, 24'hFFFFFE, 32'h100, 32'd0, 32'd0, 4'd0, 0);
    check_branch();
    check("br_back", branch_address, 32'h000000F8);
    tick();
    drive(4'd0, 0, 1, 0, 0, 0, 0, 12'h000, 24'h000001, 32'hFFFFFFFC, 32'd0, 32'd0, 4'd0, 0);
    check_branch();
    check("br_wrap", branch_address, 32'h00000000);
    tick();

    // Random traffic with occasional freeze
    for (int i = 0; i < 80; i++) begin
      logic mr, mw;
      mr = ($urandom_range(0, 7) == 0);
      mw = !mr && ($urandom_range(0, 7) == 0);
      drive(4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, mw,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom),
            24'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
            ($urandom_range(0, 3) == 0));
      check_branch();
      tick();
    end

    // Reset asserted mid-freeze with live, nonzero state
    drive(4'b0010, 1, 0, 0, 0, 1, 1, 12'h001, 24'd0, 32'd0, 32'h7FFFFFFF, 32'h55, 4'd3, 0);
    tick();
    drive(4'b0010, 1, 1, 0, 0, 1, 1, 12'h0AB, 24'd7, 32'h40, 32'h123, 32'h456, 4'd7, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset("rst_mid");
    sb_q.delete();
    @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    m_nzcv = 4'd0;
    last_exp = '0;
    drive(4'd0, 0, 0, 0, 0, 0, 0, 12'h000, 24'd0, 32'd0, 32'd0, 32'd0, 4'd0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
